reg_scoreboard: RTL
===================

Name: reg_scoreboard

Overview:
Issue-side hazard controller for the 32-entry architectural register file (64-bit data, 5-bit creg_addr_t, x0 hardwired zero, synchronous write, combinational read). It tracks outstanding writes per register and gates instruction issue until source operands are readable from the regfile. It also blocks a destination whose pending-write counter is saturated. It sits between decode/issue and execute, and writeback ports retire entries.

Parameters:
NUM_WB, 2, number of writeback clear ports; matches regfile WRITE_PORTS.
CNT_W, 2, width of the per-register outstanding-write counter; max pending writes = 2^CNT_W-1.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
issue_valid  in  1  decode presents an instruction
issue_ready  out  1  scoreboard accepts it this cycle
issue_use1  in  1  instruction reads ra1
issue_ra1  in  5  source register 1
issue_use2  in  1  instruction reads ra2
issue_ra2  in  5  source register 2
issue_wen  in  1  instruction writes a register
issue_wa  in  5  destination register
wb_valid  in  NUM_WB  writeback port j writes the regfile this cycle
wb_wa  in  NUM_WB x 5  writeback destination per port
flush  in  1  pipeline flush; discard all pending writes
busy  out  32  per-register pending flag (cnt != 0); bit 0 always 0
stall_cnt  out  32  performance counter of stalled issue cycles
err  out  1  sticky underflow flag

Behaviour:
- State: cnt[1..31], CNT_W bits each; cnt[0] is not stored and reads 0.
- Reset: all cnt=0, busy=0, stall_cnt=0, err=0. Reset has priority over flush and all other inputs. Reset mid-operation discards pending state with no residue.
- busy[i] = (cnt[i] != 0); driven from registers only, no input-to-busy path.
- issue_ready is combinational and equals !flush && !haz1 && !haz2 && !wsat, where:
  - haz1 = issue_use1 && busy[ra1]
  - haz2 = issue_use2 && busy[ra2]
  - wsat = issue_wen && wa!=0 && cnt[wa]==max
- issue_ready does not depend on issue_valid.
- No same-cycle writeback bypass. A wb clearing reg r in cycle t releases readers of r in cycle t+1, when the regfile write is visible.
- fire = issue_valid && issue_ready.
- Counter update per register i≥1, evaluated every cycle:
  - inc = fire && issue_wen && issue_wa==i
  - dec = number of ports j with wb_valid[j] && wb_wa[j]==i (0..NUM_WB)
  - next cnt = cnt + inc - dec
  - Simultaneous inc and dec on the same register nets out.
  - A WAW issue to a busy destination is allowed while cnt < max.
- Underflow: if dec > cnt + inc, clamp next cnt to 0 and set err=1 (sticky until reset).
- Writes to x0 (issue or wb) are ignored and never affect cnt or busy.
- flush: all cnt go to 0 next cycle. issue_ready=0 during the flush cycle. wb in the flush cycle is ignored and does not set err.
- stall_cnt: +1 each cycle with issue_valid && !issue_ready (flush cycles included); saturates at 0xFFFF_FFFF.
- Latency: accept decision in the same cycle; busy reflects an accepted issue from the next cycle.

Decomposition:
- Package common: creg_addr_t (5 bits), AREG_WRITE_PORTS, and a new constant SB_CNT_W = 2 used as the default for CNT_W.
- One natural sub-module, sb_counter: a single register's counter with inc, dec count, flush, reset, and underflow output. Instantiate it 31 times through a generate loop. The top level handles hazard checks, stall_cnt, and err aggregation.

Test Plan:
- Reset then idle: busy=0, issue_ready=1 for any sources, stall_cnt=0, err=0.
- Issue wen wa=5. Next cycle, issue use1 ra1=5: issue_ready=0 and stall_cnt increments. wb_valid[0], wb_wa=5 in cycle t gives issue_ready=0 in t and 1 in t+1.
- Issue wen wa=3 three times (CNT_W=2): cnt[3]=3. A 4th wen wa=3 gives issue_ready=0. wb on both ports to reg 3 in one cycle: cnt[3]=1 next cycle.
- Same cycle: fire with wen wa=7 while wb_wa[1]=7 and cnt[7]=1: cnt[7] stays 1 and busy[7] stays 1.
- x0 handling: issue wen wa=0 and use1 ra1=0 gives busy[0]=0 and issue_ready=1. A wb to x0 with cnt idle leaves err=0.
- With regs 2, 9, 31 pending, assert flush together with issue_valid: issue_ready=0, busy=0 next cycle, err=0. Then wb to reg 2 with cnt=0 gives err=1, and err stays 1 until reset.

Source files
------------

// File: rtl/reg_scoreboard_pkg.sv
// Shared architectural-register types and scoreboard sizing constants.
package reg_scoreboard_pkg;
    typedef logic [4:0] creg_addr_t;

    localparam int AREG_WRITE_PORTS = 2;
    localparam int SB_CNT_W         = 2;
endpackage

// File: rtl/reg_scoreboard_sb_counter.sv
// Outstanding-write counter for one architectural register; clamps at zero
// and flags underflow when more writebacks retire than are pending.
module sb_counter
    import reg_scoreboard_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W,
    parameter int DEC_W = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             inc,
    input  logic [DEC_W-1:0] dec,
    output logic [CNT_W-1:0] cnt,
    output logic             underflow
);
    localparam int SUM_W = ((CNT_W > DEC_W) ? CNT_W : DEC_W) + 1;

    logic [CNT_W-1:0] r_cnt;
    logic [SUM_W-1:0] w_sum;
    logic [SUM_W-1:0] w_dec;

    // NOTE: every output of a combinational block is assigned before any
    // condition so that no path leaves it holding a value (no latch).
    always_comb begin
        w_sum     = SUM_W'(r_cnt) + SUM_W'(inc);
        w_dec     = SUM_W'(dec);
        underflow = !flush && (w_dec > w_sum);
    end

    // NOTE: state registers use non-blocking assignment so every flop samples
    // the pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (flush || underflow) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= CNT_W'(w_sum - w_dec);
        end
    end

    assign cnt = r_cnt;
endmodule

// File: rtl/reg_scoreboard.sv
// Issue-side register scoreboard: gates issue on pending writes to sources
// and on saturated destination counters; writeback ports retire entries.
module reg_scoreboard
    import reg_scoreboard_pkg::*;
#(
    parameter int NUM_WB = AREG_WRITE_PORTS,
    parameter int CNT_W  = SB_CNT_W
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   issue_valid,
    output logic                   issue_ready,
    input  logic                   issue_use1,
    input  logic [4:0]             issue_ra1,
    input  logic                   issue_use2,
    input  logic [4:0]             issue_ra2,
    input  logic                   issue_wen,
    input  logic [4:0]             issue_wa,
    input  logic [NUM_WB-1:0]      wb_valid,
    input  logic [NUM_WB-1:0][4:0] wb_wa,
    input  logic                   flush,
    output logic [31:0]            busy,
    output logic [31:0]            stall_cnt,
    output logic                   err
);
    localparam int               DEC_W   = $clog2(NUM_WB + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic [CNT_W-1:0] w_cnt [32];
    logic [31:1]      w_underflow;
    logic             w_haz1;
    logic             w_haz2;
    logic             w_wsat;
    logic             w_fire;
    logic             r_err;
    logic [31:0]      r_stall_cnt;

    // x0 is hardwired zero: never pending, never counted.
    assign w_cnt[0] = '0;
    assign busy[0]  = 1'b0;

    for (genvar i = 1; i < 32; i++) begin : g_reg
        logic             w_inc;
        logic [DEC_W-1:0] w_dec;

        always_comb begin
            w_inc = w_fire && issue_wen && (issue_wa == creg_addr_t'(i));
            w_dec = '0;
            for (int j = 0; j < NUM_WB; j++) begin
                if (wb_valid[j] && (wb_wa[j] == creg_addr_t'(i))) begin
                    w_dec = w_dec + DEC_W'(1);
                end
            end
        end

        sb_counter #(
            .CNT_W (CNT_W),
            .DEC_W (DEC_W)
        ) u_cnt (
            .clk       (clk),
            .reset     (reset),
            .flush     (flush),
            .inc       (w_inc),
            .dec       (w_dec),
            .cnt       (w_cnt[i]),
            .underflow (w_underflow[i])
        );

        assign busy[i] = |w_cnt[i];
    end

    // Readers see the regfile write only the cycle after writeback, so the
    // hazard looks at registered counters with no writeback bypass.
    assign w_haz1      = issue_use1 && busy[issue_ra1];
    assign w_haz2      = issue_use2 && busy[issue_ra2];
    assign w_wsat      = issue_wen && (issue_wa != '0) && (w_cnt[issue_wa] == CNT_MAX);
    assign issue_ready = !flush && !w_haz1 && !w_haz2 && !w_wsat;
    assign w_fire      = issue_valid && issue_ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_err       <= 1'b0;
            r_stall_cnt <= '0;
        end else begin
            r_err <= r_err | (|w_underflow);
            if (issue_valid && !issue_ready && (r_stall_cnt != '1)) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
        end
    end

    assign err       = r_err;
    assign stall_cnt = r_stall_cnt;
endmodule
